// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute stage and muldiv_unit.
// The master drives the request; the slave (the unit) returns status and the {HI,LO} result.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       busA;
    logic [WIDTH-1:0]       busB;
    logic                   busy;
    logic                   multWe;
    logic [2*WIDTH-1:0]     busmult;

    modport master (
        output start, op, busA, busB,
        input  busy, multWe, busmult
    );

    modport slave (
        input  start, op, busA, busB,
        output busy, multWe, busmult
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit producing {HI,LO} with a one-cycle multWe strobe.
// Define MULDIV_FAST_MULT_EN to finish mult/multu in a single RUN cycle with a combinational multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic [2*WIDTH-1:0]   busmult_q, busmult_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     step_hi, step_lo;
    logic [2*WIDTH-1:0]   result;
    logic                 fast_done;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0]   fast_prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            busmult_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            busmult_q <= busmult_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        work_d    = work_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        busmult_d = busmult_q;
        fast_done = 1'b0;

        sign_a = ~bus.op[0] & bus.busA[WIDTH-1];
        sign_b = ~bus.op[0] & bus.busB[WIDTH-1];
        mag_a  = sign_a ? -bus.busA : bus.busA;
        mag_b  = sign_b ? -bus.busB : bus.busB;

        // Multiply: acc holds the running upper half, work shifts the multiplier out and the product low bits in.
        mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: acc is the partial remainder, work shifts the dividend out and quotient bits in.
        div_shift = {acc_q, work_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;

        if (op_q[1]) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {work_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_q[WIDTH-1:1]};
        end
`ifdef MULDIV_FAST_MULT_EN
        fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, work_q};
        if (!op_q[1]) begin
            {step_hi, step_lo} = fast_prod;
            fast_done = 1'b1;
        end
`endif

        if (op_q[1]) begin
            result = {neg_hi_q ? -step_hi : step_hi, neg_lo_q ? -step_lo : step_lo};
        end else begin
            result = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        end

        case (state_q)
            RUN: begin
                acc_d  = step_hi;
                work_d = step_lo;
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
                if (count_q == '0 || fast_done) begin
                    state_d   = DONE;
                    busmult_d = result;
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    op_d    = bus.op;
                    acc_d   = '0;
                    count_d = CW'(WIDTH - 1);
                    if (bus.op[1]) begin
                        // Divide by zero must keep a positive all-ones quotient, so no quotient negation then.
                        work_d   = mag_a;
                        opnd_d   = mag_b;
                        neg_lo_d = (sign_a ^ sign_b) & (|bus.busB);
                        neg_hi_d = sign_a;
                    end else begin
                        work_d   = mag_b;
                        opnd_d   = mag_a;
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = 1'b0;
                    end
                end
            end
        endcase
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.multWe  = (state_q == DONE);
    assign bus.busmult = busmult_q;
endmodule
